// File: rtl/axi_lite_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_mem
//
// AXI4-Lite responder backed by a DEPTH x 32-bit register file. Write address
// and write data are accepted independently (either order or together); once
// both are held the write is committed and a BRESP is returned after
// WAIT_CYCLES extra cycles. Reads return RDATA/RRESP after the same number of
// extra cycles. Addresses outside [BASE_ADDR, BASE_ADDR + DEPTH*4) answer
// SLVERR, leave memory untouched on writes and return zero data on reads.
//
// Ports
//   ACLK, ARESET            clock, synchronous active-high reset
//   AW*  (ADDR/VALID/READY) write address channel; AWCACHE/AWPROT ignored
//   W*   (DATA/VALID/READY) write data channel (full-word writes only)
//   B*   (RESP/VALID/READY) write response channel (00 OKAY, 10 SLVERR)
//   AR*  (ADDR/VALID/READY) read address channel; ARCACHE/ARPROT ignored
//   R*   (DATA/RESP/VALID/READY) read data channel (00 OKAY, 10 SLVERR)
// ---------------------------------------------------------------------------
module axi_lite_slave_mem #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [3:0]  AWCACHE,
    input  logic [2:0]  AWPROT,
    input  logic [31:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [3:0]  ARCACHE,
    input  logic [2:0]  ARPROT,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wState_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rState_t;

    logic [31:0] r_mem [DEPTH];

    wState_t     r_wState;
    logic        r_awReady;
    logic        r_wReady;
    logic        r_awHeld;
    logic        r_wHeld;
    logic [31:0] r_awAddr;
    logic [31:0] r_wData;
    logic [3:0]  r_wCnt;
    logic        r_bValid;
    logic [1:0]  r_bResp;

    rState_t     r_rState;
    logic        r_arReady;
    logic [31:0] r_arAddr;
    logic [3:0]  r_rCnt;
    logic        r_rValid;
    logic [1:0]  r_rResp;
    logic [31:0] r_rData;

    // Cache/protection attributes carry no meaning for a plain register file.
    logic w_unused;
    assign w_unused = ^{AWCACHE, AWPROT, ARCACHE, ARPROT};

    // Write path: the address/data used for the commit come from the latch
    // when already held, otherwise straight from the bus in the handshake cycle.
    logic             w_awHs;
    logic             w_wHs;
    logic [31:0]      w_wrAddr;
    logic [31:0]      w_wrData;
    logic [31:0]      w_wrOffset;
    logic             w_wrInRange;
    logic [IDX_W-1:0] w_wrIdx;
    logic             w_commit;

    assign w_awHs      = AWVALID & r_awReady;
    assign w_wHs       = WVALID & r_wReady;
    assign w_wrAddr    = r_awHeld ? r_awAddr : AWADDR;
    assign w_wrData    = r_wHeld ? r_wData : WDATA;
    // Unsigned wrap-around makes addresses below BASE_ADDR fail this compare too.
    assign w_wrOffset  = w_wrAddr - BASE_ADDR;
    assign w_wrInRange = (w_wrOffset < SPAN);
    assign w_wrIdx     = w_wrOffset[IDX_W+1:2];
    assign w_commit    = (r_wState == W_IDLE) && (r_awHeld || w_awHs) && (r_wHeld || w_wHs);

    // Read path: in R_IDLE the sample address is the bus (zero-wait case),
    // afterwards it is the latched address.
    logic             w_arHs;
    logic [31:0]      w_rdAddr;
    logic [31:0]      w_rdOffset;
    logic             w_rdInRange;
    logic [IDX_W-1:0] w_rdIdx;

    assign w_arHs      = ARVALID & r_arReady;
    assign w_rdAddr    = (r_rState == R_IDLE) ? ARADDR : r_arAddr;
    assign w_rdOffset  = w_rdAddr - BASE_ADDR;
    assign w_rdInRange = (w_rdOffset < SPAN);
    assign w_rdIdx     = w_rdOffset[IDX_W+1:2];

    // Write FSM and memory. READYs are registered: they drop on the edge that
    // completes their handshake and only rise one cycle after entering W_IDLE
    // with nothing latched, which bounds throughput to one write per 3 cycles.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wState  <= W_IDLE;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_awAddr  <= '0;
            r_wData   <= '0;
            r_wCnt    <= '0;
            r_bValid  <= 1'b0;
            r_bResp   <= RESP_OKAY;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_wState)
                W_IDLE: begin
                    if (w_commit) begin
                        if (w_wrInRange) begin
                            r_mem[w_wrIdx] <= w_wrData;
                        end
                        r_bResp   <= w_wrInRange ? RESP_OKAY : RESP_SLVERR;
                        r_awHeld  <= 1'b1;
                        r_wHeld   <= 1'b1;
                        r_awAddr  <= w_wrAddr;
                        r_wData   <= w_wrData;
                        r_awReady <= 1'b0;
                        r_wReady  <= 1'b0;
                        if (WAIT_INIT == 4'd0) begin
                            r_bValid <= 1'b1;
                            r_wState <= W_RESP;
                        end else begin
                            r_wCnt   <= WAIT_INIT;
                            r_wState <= W_WAIT;
                        end
                    end else begin
                        if (w_awHs) begin
                            r_awAddr  <= AWADDR;
                            r_awHeld  <= 1'b1;
                            r_awReady <= 1'b0;
                        end else begin
                            r_awReady <= ~r_awHeld;
                        end
                        if (w_wHs) begin
                            r_wData  <= WDATA;
                            r_wHeld  <= 1'b1;
                            r_wReady <= 1'b0;
                        end else begin
                            r_wReady <= ~r_wHeld;
                        end
                    end
                end
                W_WAIT: begin
                    if (r_wCnt <= 4'd1) begin
                        r_wCnt   <= 4'd0;
                        r_bValid <= 1'b1;
                        r_wState <= W_RESP;
                    end else begin
                        r_wCnt <= r_wCnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_bValid <= 1'b0;
                        r_awHeld <= 1'b0;
                        r_wHeld  <= 1'b0;
                        r_wState <= W_IDLE;
                    end
                end
                default: begin
                    r_wState <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM. Memory is sampled on the edge RVALID rises; a write committed
    // on that same edge is not yet visible, so the old word is returned.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rState  <= R_IDLE;
            r_arReady <= 1'b0;
            r_arAddr  <= '0;
            r_rCnt    <= '0;
            r_rValid  <= 1'b0;
            r_rResp   <= RESP_OKAY;
            r_rData   <= '0;
        end else begin
            case (r_rState)
                R_IDLE: begin
                    if (w_arHs) begin
                        r_arAddr  <= ARADDR;
                        r_arReady <= 1'b0;
                        if (WAIT_INIT == 4'd0) begin
                            r_rValid <= 1'b1;
                            r_rData  <= w_rdInRange ? r_mem[w_rdIdx] : 32'h0;
                            r_rResp  <= w_rdInRange ? RESP_OKAY : RESP_SLVERR;
                            r_rState <= R_RESP;
                        end else begin
                            r_rCnt   <= WAIT_INIT;
                            r_rState <= R_WAIT;
                        end
                    end else begin
                        r_arReady <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_rCnt <= 4'd1) begin
                        r_rCnt   <= 4'd0;
                        r_rValid <= 1'b1;
                        r_rData  <= w_rdInRange ? r_mem[w_rdIdx] : 32'h0;
                        r_rResp  <= w_rdInRange ? RESP_OKAY : RESP_SLVERR;
                        r_rState <= R_RESP;
                    end else begin
                        r_rCnt <= r_rCnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        r_rValid <= 1'b0;
                        r_rState <= R_IDLE;
                    end
                end
                default: begin
                    r_rState <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = r_awReady;
    assign WREADY  = r_wReady;
    assign BVALID  = r_bValid;
    assign BRESP   = r_bResp;
    assign ARREADY = r_arReady;
    assign RVALID  = r_rValid;
    assign RRESP   = r_rResp;
    assign RDATA   = r_rData;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_mem
//
// Drives two responders (zero wait states and three wait states) from one
// master model; a select bit gates the VALIDs to the active instance and
// muxes its outputs back. Expected data/responses come from a word-array
// model of each memory and from the access rules (range, latency).
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_mem;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel   = 1'b0;

    logic [31:0] awAddr = '0;
    logic        awValid = 1'b0;
    logic [31:0] wData = '0;
    logic        wValid = 1'b0;
    logic        bReady = 1'b0;
    logic [31:0] arAddr = '0;
    logic        arValid = 1'b0;
    logic        rReady = 1'b0;

    logic        awReady0, wReady0, bValid0, arReady0, rValid0;
    logic [1:0]  bResp0, rResp0;
    logic [31:0] rData0;
    logic        awReady3, wReady3, bValid3, arReady3, rValid3;
    logic [1:0]  bResp3, rResp3;
    logic [31:0] rData3;

    logic        awReadyM, wReadyM, bValidM, arReadyM, rValidM;
    logic [1:0]  bRespM, rRespM;
    logic [31:0] rDataM;

    int compared = 0;
    int failed   = 0;

    logic [31:0] model [2][DEPTH];

    always #5 clock = ~clock;

    axi_lite_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
        .ACLK(clock), .ARESET(reset),
        .AWADDR(awAddr), .AWVALID(awValid & ~sel), .AWREADY(awReady0),
        .AWCACHE(4'h0), .AWPROT(3'h0),
        .WDATA(wData), .WVALID(wValid & ~sel), .WREADY(wReady0),
        .BRESP(bResp0), .BVALID(bValid0), .BREADY(bReady & ~sel),
        .ARADDR(arAddr), .ARVALID(arValid & ~sel), .ARREADY(arReady0),
        .ARCACHE(4'h0), .ARPROT(3'h0),
        .RDATA(rData0), .RRESP(rResp0), .RVALID(rValid0), .RREADY(rReady & ~sel)
    );

    axi_lite_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u3 (
        .ACLK(clock), .ARESET(reset),
        .AWADDR(awAddr), .AWVALID(awValid & sel), .AWREADY(awReady3),
        .AWCACHE(4'hF), .AWPROT(3'h7),
        .WDATA(wData), .WVALID(wValid & sel), .WREADY(wReady3),
        .BRESP(bResp3), .BVALID(bValid3), .BREADY(bReady & sel),
        .ARADDR(arAddr), .ARVALID(arValid & sel), .ARREADY(arReady3),
        .ARCACHE(4'hF), .ARPROT(3'h7),
        .RDATA(rData3), .RRESP(rResp3), .RVALID(rValid3), .RREADY(rReady & sel)
    );

    assign awReadyM = sel ? awReady3 : awReady0;
    assign wReadyM  = sel ? wReady3  : wReady0;
    assign bValidM  = sel ? bValid3  : bValid0;
    assign bRespM   = sel ? bResp3   : bResp0;
    assign arReadyM = sel ? arReady3 : arReady0;
    assign rValidM  = sel ? rValid3  : rValid0;
    assign rRespM   = sel ? rResp3   : rResp0;
    assign rDataM   = sel ? rData3   : rData0;

    // One comparison: counts it, and on mismatch counts the failure and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ctrlVec();
        return {23'b0, awReadyM, wReadyM, bValidM, bRespM, arReadyM, rValidM, rRespM};
    endfunction

    // One full transaction on the selected instance. For writes, dA/dB delay
    // AWVALID/WVALID; for reads, dA delays ARVALID. respDly holds B/RREADY low.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                                 input int dA, input int dB, input int respDly);
        int          waitCy;
        int          k;
        int          lastHs;
        bit          aDone;
        bit          dDone;
        bit          inRange;
        logic [1:0]  expResp;
        logic [31:0] expData;
        waitCy  = sel ? 3 : 0;
        k       = 0;
        lastHs  = 0;
        aDone   = 1'b0;
        dDone   = !isWrite;
        inRange = (addr < 32'(DEPTH * 4));
        expResp = inRange ? 2'b00 : 2'b10;
        if (isWrite) begin
            awAddr = addr;
            wData  = data;
        end else begin
            arAddr = addr;
        end
        while (!(aDone && dDone) && k < 50) begin
            if (isWrite) begin
                awValid = !aDone && (k >= dA);
                wValid  = !dDone && (k >= dB);
                if (aDone) checkOutput("awready_after_hs", {31'b0, awReadyM}, 32'd0);
                if (dDone) checkOutput("wready_after_hs", {31'b0, wReadyM}, 32'd0);
                checkOutput("bvalid_before_commit", {31'b0, bValidM}, 32'd0);
                if (awValid && awReadyM) begin aDone = 1'b1; lastHs = k; end
                if (wValid && wReadyM) begin dDone = 1'b1; lastHs = k; end
            end else begin
                arValid = (k >= dA);
                checkOutput("rvalid_before_ar", {31'b0, rValidM}, 32'd0);
                if (arValid && arReadyM) begin aDone = 1'b1; lastHs = k; end
            end
            @(negedge clock);
            k++;
        end
        awValid = 1'b0;
        wValid  = 1'b0;
        arValid = 1'b0;
        if (!(aDone && dDone)) begin
            checkOutput("addr_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        if (isWrite && inRange) model[sel][addr[5:2]] = data;
        expData = (!isWrite && inRange) ? model[sel][addr[5:2]] : 32'h0;
        while (!(isWrite ? bValidM : rValidM) && k < lastHs + 40) begin
            if (isWrite) checkOutput("readys_low_during_wait", {30'b0, awReadyM, wReadyM}, 32'd0);
            else         checkOutput("arready_low_during_wait", {31'b0, arReadyM}, 32'd0);
            @(negedge clock);
            k++;
        end
        checkOutput(isWrite ? "b_latency" : "r_latency", 32'(k - lastHs), 32'(waitCy + 1));
        for (int i = 0; i <= respDly; i++) begin
            if (isWrite) begin
                checkOutput("bvalid_held", {31'b0, bValidM}, 32'd1);
                checkOutput("bresp", {30'b0, bRespM}, {30'b0, expResp});
                checkOutput("readys_low_in_resp", {30'b0, awReadyM, wReadyM}, 32'd0);
            end else begin
                checkOutput("rvalid_held", {31'b0, rValidM}, 32'd1);
                checkOutput("rresp", {30'b0, rRespM}, {30'b0, expResp});
                checkOutput("rdata", rDataM, expData);
                checkOutput("arready_low_in_resp", {31'b0, arReadyM}, 32'd0);
            end
            if (i == respDly) begin
                if (isWrite) bReady = 1'b1;
                else         rReady = 1'b1;
            end
            @(negedge clock);
        end
        bReady = 1'b0;
        rReady = 1'b0;
        checkOutput(isWrite ? "bvalid_cleared" : "rvalid_cleared",
                    {31'b0, isWrite ? bValidM : rValidM}, 32'd0);
        @(negedge clock);
        if (isWrite) checkOutput("readys_back", {30'b0, awReadyM, wReadyM}, 32'd3);
        else         checkOutput("arready_back", {31'b0, arReadyM}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) model[s][i] = 32'h0;

        // Reset state of both instances
        repeat (3) @(negedge clock);
        sel = 1'b0; #1;
        checkOutput("reset_ctrl_w0", ctrlVec(), 32'd0);
        checkOutput("reset_rdata_w0", rDataM, 32'd0);
        sel = 1'b1; #1;
        checkOutput("reset_ctrl_w3", ctrlVec(), 32'd0);
        checkOutput("reset_rdata_w3", rDataM, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("readys_after_release_w3", {29'b0, awReadyM, wReadyM, arReadyM}, 32'd7);
        sel = 1'b0; #1;
        checkOutput("readys_after_release_w0", {29'b0, awReadyM, wReadyM, arReadyM}, 32'd7);

        // Directed cases on the zero-wait instance
        applyStimulus(1'b1, 32'h8, 32'hA5A5_1234, 0, 0, 0);
        applyStimulus(1'b0, 32'h8, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 32'h4, 32'h1111_2222, 3, 0, 0);
        applyStimulus(1'b0, 32'h4, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 2, 0);
        applyStimulus(1'b0, 32'h40, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 32'h3C, 32'h0BAD_F00D, 1, 0, 5);
        applyStimulus(1'b0, 32'h3F, 32'h0, 0, 0, 5);

        // Directed cases on the three-wait instance
        sel = 1'b1;
        @(negedge clock);
        applyStimulus(1'b0, 32'h8, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 32'h8, 32'h5555_AAAA, 0, 0, 0);
        applyStimulus(1'b0, 32'h9, 32'h0, 1, 0, 2);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 0, 0, 1);

        // Randomised traffic on each instance, including out-of-range words
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clock);
            for (int n = 0; n < 30; n++) begin
                logic [31:0] a;
                a = (32'($urandom_range(0, DEPTH + 3)) << 2) | 32'($urandom_range(0, 3));
                applyStimulus(1'($urandom_range(0, 1)), a, $urandom,
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 3)));
            end
        end

        // Reset pulsed while a write response is pending
        sel = 1'b0;
        @(negedge clock);
        awAddr = 32'h10; wData = 32'hCAFE_0001;
        awValid = 1'b1; wValid = 1'b1;
        @(negedge clock);
        awValid = 1'b0; wValid = 1'b0;
        checkOutput("bvalid_before_reset", {31'b0, bValidM}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("ctrl_in_reset", ctrlVec(), 32'd0);
        checkOutput("rdata_in_reset", rDataM, 32'd0);
        reset = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) model[s][i] = 32'h0;
        @(negedge clock);
        checkOutput("readys_after_reset", {29'b0, awReadyM, wReadyM, arReadyM}, 32'd7);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'(i * 4), 32'h0, 0, 0, 0);
        sel = 1'b1;
        @(negedge clock);
        applyStimulus(1'b0, 32'h8, 32'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
